// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, PMOD pin map and capture datatypes for the VGA PMOD sink.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE    = 640;
    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_H_START     = 144;
    localparam int VGA_V_ACTIVE    = 480;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_V_START     = 35;
    localparam int VGA_LOCK_FRAMES = 2;
    localparam int VGA_FIFO_DEPTH  = 16;

    localparam int PMOD_R1    = 0;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_HSYNC = 7;

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} cap_state_t;

    typedef struct packed {
        logic [5:0] rgb;
        logic [9:0] x;
        logic [9:0] y;
        logic       sof;
        logic       eol;
    } pixel_word_t;

    // Reorders the PMOD bundle into {R1,R0,G1,G0,B1,B0}.
    function automatic logic [5:0] pmod_rgb(input logic [7:0] p);
        return {p[PMOD_R1], p[PMOD_R0], p[PMOD_G1], p[PMOD_G0], p[PMOD_B1], p[PMOD_B0]};
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_cap_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on rd_data whenever empty is low.
module vga_cap_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A read in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vga_pmod_capture.sv
// VGA PMOD sink: locks onto the sync timing and streams active pixels with x/y and frame markers.
// Handshake: a word moves when px_valid && px_ready at a rising clk; px_valid never depends on px_ready.
module vga_pmod_capture
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_START     = VGA_H_START,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_START     = VGA_V_START,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter int FIFO_DEPTH  = VGA_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [5:0]  px_rgb,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_sof,
    output logic        px_eol,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] frame_cnt,
    output cap_state_t  dbg_state
);
    localparam int PW = $bits(pixel_word_t);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FIRST_PX = 10'(H_START);
    localparam logic [9:0] H_LAST_PX  = 10'(H_START + H_ACTIVE - 1);
    localparam logic [9:0] V_FIRST_PX = 10'(V_START);
    localparam logic [9:0] V_LAST_PX  = 10'(V_START + V_ACTIVE - 1);
    localparam logic [9:0] X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [7:0] GOOD_LAST  = 8'(LOCK_FRAMES - 1);

    // vga_qq is the pixel that hcnt/vcnt describe; vga_q is one sample ahead for edge detection.
    logic [7:0]  vga_q;
    logic [7:0]  vga_qq;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        vs_flag;
    logic [7:0]  good_cnt;
    logic        armed;
    cap_state_t  state;

    logic        h_edge, vs_fall, v_line, line_bad, frame_bad;
    logic        pix_active, pix_sof, pix_eol, wr_en, wr_ok, rd_fire;
    logic [9:0]  pix_x, pix_y;
    logic        fifo_full, fifo_empty;
    logic [PW-1:0] rd_data;
    pixel_word_t wr_word, head;

    always_comb begin
        h_edge     = vga_qq[PMOD_HSYNC] & ~vga_q[PMOD_HSYNC];
        vs_fall    = vga_qq[PMOD_VSYNC] & ~vga_q[PMOD_VSYNC];
        v_line     = h_edge & (vs_flag | vs_fall);
        line_bad   = h_edge && (hcnt != H_LAST);
        frame_bad  = v_line && (vcnt != V_LAST);
        pix_x      = hcnt - H_FIRST_PX;
        pix_y      = vcnt - V_FIRST_PX;
        pix_active = (state == LOCKED) && (hcnt >= H_FIRST_PX) && (hcnt <= H_LAST_PX)
                     && (vcnt >= V_FIRST_PX) && (vcnt <= V_LAST_PX);
        pix_sof    = (pix_x == 10'd0) && (pix_y == 10'd0);
        pix_eol    = (pix_x == X_LAST);
        wr_en      = pix_active && (armed || pix_sof);
        rd_fire    = px_valid && px_ready;
        wr_ok      = wr_en && (!fifo_full || rd_fire);
        wr_word    = '{rgb: pmod_rgb(vga_qq), x: pix_x, y: pix_y, sof: pix_sof, eol: pix_eol};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_q   <= 8'h88;
            vga_qq  <= 8'h88;
            hcnt    <= '0;
            vcnt    <= '0;
            vs_flag <= 1'b0;
        end else begin
            vga_q  <= vga_in;
            vga_qq <= vga_q;
            hcnt   <= h_edge ? 10'd0 : sat_inc(hcnt);
            if (h_edge) begin
                vcnt    <= (vs_flag | vs_fall) ? 10'd0 : sat_inc(vcnt);
                vs_flag <= 1'b0;
            end else if (vs_fall) begin
                vs_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (v_line) begin
                        state    <= VERIFY;
                        good_cnt <= '0;
                    end
                end
                VERIFY: begin
                    if (line_bad || frame_bad) begin
                        state <= HUNT;
                    end else if (v_line) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt == GOOD_LAST) state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad) state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

    // armed keeps a partially seen frame out of the stream until the next (0,0) pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (state != LOCKED)         armed <= 1'b0;
            else if (pix_active && pix_sof) armed <= 1'b1;
            if (wr_en && !wr_ok)         overflow <= 1'b1;
            if (wr_ok && pix_x == X_LAST && pix_y == Y_LAST) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    vga_cap_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_word),
        .rd_en   (px_ready),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head      = rd_data;
    assign px_valid  = !fifo_empty;
    assign px_rgb    = px_valid ? head.rgb : 6'd0;
    assign px_x      = px_valid ? head.x   : 10'd0;
    assign px_y      = px_valid ? head.y   : 10'd0;
    assign px_sof    = px_valid && head.sof;
    assign px_eol    = px_valid && head.eol;
    assign locked    = (state == LOCKED);
    assign dbg_state = state;

endmodule
